rgb_frame_source: RTL and testbench
===================================

// Module: rgb_frame_source
// PURPOSE
//  Synthesizable pixel-stream source on pixclk. Emits IMG_WIDTH x IMG_HEIGHT frames of
//  valid/RGB with programmable line and frame blanking and four test patterns.
//  Sits directly upstream of the d5m-side pixel checker. That checker consumes valid/red/green/blue
//  and counts x/y up to the image size, so exactly W*H valid beats per frame are mandatory.
// PARAMETERS
//  IMG_WIDTH   400  active pixels per line; multiple of 8, >= 8
//  IMG_HEIGHT  300  active lines per frame; >= 1
//  H_BLANK     16   idle cycles between lines; >= 1
//  V_BLANK     4    idle cycles after last pixel of a frame; >= 1
//  FRAMES      1    frames per start; 0 = free-running until reset
// PORTS
//  pixclk     in   1   pixel clock; all logic on posedge
//  reset      in   1   synchronous, active-low
//  start      in   1   1-cycle request; sampled only in IDLE
//  mode       in   2   pattern select, latched with start
//  solid_rgb  in   24  {R,G,B} for mode 3, latched with start
//  valid      out  1   active pixel this cycle
//  oRed       out  8   pixel red (0 when !valid)
//  oGreen     out  8   pixel green (0 when !valid)
//  oBlue      out  8   pixel blue (0 when !valid)
//  sof        out  1   valid && x==0 && y==0
//  eol        out  1   valid && x==IMG_WIDTH-1
//  x_coord    out  16  current pixel column
//  y_coord    out  16  current pixel line
//  busy       out  1   state != IDLE
//  done       out  1   1-cycle pulse, run complete
//  frame_cnt  out  16  frames completed since start (wraps at 2^16)
// BEHAVIOUR
//  - Reset is synchronous, active-low; clock is pixclk.
//  - Reset (reset==0): state IDLE; all outputs 0; reset beats start on the same edge.
//  - All outputs are registered.
//  - FSM IDLE->ACTIVE->{HBLANK|VBLANK}->...->DONE->IDLE.
//  - IDLE: start==1 latches mode/solid_rgb, clears x, y and frame_cnt, and enters ACTIVE.
//    The first valid appears on the cycle after start is sampled.
//  - ACTIVE: valid=1 every cycle; x increments.
//    At x==W-1: if y==H-1 go to VBLANK, else go to HBLANK.
//  - HBLANK: valid=0 for exactly H_BLANK cycles; then ACTIVE with x=0, y+1.
//  - VBLANK: valid=0 for exactly V_BLANK cycles; frame_cnt increments on entry.
//    Exit: if FRAMES!=0 and frame_cnt==FRAMES, go to DONE; else ACTIVE with x=y=0.
//  - DONE: one cycle, done=1, busy=1; next cycle IDLE. start is ignored whenever busy.
//  - x/y hold their last values during blanking; they are 0 in IDLE after reset.
//  - Patterns (mode; widths truncate to 8 b):
//    0 ramp:  R=x[7:0], G=y[7:0], B=(x+y)[7:0]
//    1 bars:  8 bars of W/8 px, driven by a bar counter (no divider), in order
//             FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000
//    2 check: 8x8 cells; x[3]^y[3] ? FFFFFF : 000000
//    3 solid: latched solid_rgb
//  - Reset mid-frame: stream stops next edge, no partial done; the next start begins at (0,0).
// STRUCTURE
//  - generic_pack holds:
//    - rgb_pattern_e (RAMP, BARS, CHECK, SOLID);
//    - src_state_e (IDLE, ACTIVE, HBLANK, VBLANK, DONE);
//    - bar colour table as a localparam array.
//  - One sub-module: rgb_pattern_gen, a combinational map of (mode, x, y, bar_idx, solid) to RGB.
//    Its result is registered in rgb_frame_source.
// TESTING
//  1. W=8,H=2,HB=2,VB=3,FRAMES=1, mode 0, start at t0:
//     - valid t0+1..t0+8 and t0+11..t0+18;
//     - done=1 at t0+22; busy=0 at t0+23; 16 beats total.
//  2. W=16, mode 1: x0-1=FFFFFF, x2-3=FFFF00, x8-9=FF00FF, x14-15=000000.
//  3. W=16, mode 2: (x7,y0)=000000, (x8,y0)=FFFFFF, (x8,y8)=000000.
//  4. FRAMES=0, W=8,H=2: frame_cnt 1,2,3 with sof once per frame;
//     start pulses while busy cause no restart and no glitch.
//  5. reset=0 at (x=3,y=1): next edge all outputs 0, state IDLE;
//     a new start yields sof with pixel (0,0).
//  6. Connect the d5m pixel checker at 400x300, mode 3 with solid_rgb=123456:
//     - 120000 valid beats, all 12/34/56;
//     - checker x/y end at (399,299).

Source files
------------

// File: rtl/generic_pack.sv
// Shared types and constants for the RGB frame source and its pattern generator.
package generic_pack;

  typedef enum logic [1:0] {
    RAMP  = 2'd0,
    BARS  = 2'd1,
    CHECK = 2'd2,
    SOLID = 2'd3
  } rgb_pattern_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACTIVE = 3'd1,
    HBLANK = 3'd2,
    VBLANK = 3'd3,
    DONE   = 3'd4
  } src_state_e;

  // Colour-bar order, left to right, as {R,G,B}.
  localparam logic [23:0] BAR_COLOURS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/rgb_frame_source_pattern_gen.sv
// Combinational pattern map: (mode, x, y, bar index, solid colour) -> {R,G,B}.
// Only the low coordinate bits matter to every pattern, so only those come in.
module rgb_pattern_gen
  import generic_pack::*;
(
  input  rgb_pattern_e mode,
  input  logic [7:0]   x,
  input  logic [7:0]   y,
  input  logic [2:0]   bar_idx,
  input  logic [23:0]  solid,
  output logic [23:0]  rgb
);

  logic [7:0] diag;

  // Select the pixel colour for the requested pattern.
  always_comb begin
    rgb  = 24'h000000;
    diag = x + y;
    case (mode)
      RAMP:    rgb = {x, y, diag};
      BARS:    rgb = BAR_COLOURS[bar_idx];
      CHECK:   rgb = (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h000000;
      SOLID:   rgb = solid;
      default: rgb = 24'h000000;
    endcase
  end

endmodule

// File: rtl/rgb_frame_source.sv
// Pixel-stream source: W x H frames of valid/RGB with line and frame blanking.
// Handshake: none upstream; valid is a pure strobe (no ready), one pixel per
// cycle while valid=1, and the downstream consumer must accept every beat.
module rgb_frame_source
  import generic_pack::*;
#(
  parameter int IMG_WIDTH  = 400,
  parameter int IMG_HEIGHT = 300,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 4,
  parameter int FRAMES     = 1
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        valid,
  output logic [7:0]  oRed,
  output logic [7:0]  oGreen,
  output logic [7:0]  oBlue,
  output logic        sof,
  output logic        eol,
  output logic [15:0] x_coord,
  output logic [15:0] y_coord,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt,
  output src_state_e  dbg_state
);

  localparam logic [15:0] LAST_X   = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] LAST_Y   = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0] LAST_HB  = 16'(H_BLANK - 1);
  localparam logic [15:0] LAST_VB  = 16'(V_BLANK - 1);
  localparam logic [15:0] LAST_BAR = 16'(IMG_WIDTH / 8 - 1);

  src_state_e   state, state_n;
  rgb_pattern_e mode_q, mode_n;
  logic [23:0]  solid_q, solid_n;
  logic [15:0]  x_n, y_n, frame_n;
  logic [15:0]  blank_cnt, blank_n;
  logic [15:0]  bar_cnt, bar_cnt_n;
  logic [2:0]   bar_idx, bar_idx_n;
  logic [23:0]  pix;
  logic         act_n;

  assign dbg_state = state;
  assign act_n     = (state_n == ACTIVE);

  // Pattern is evaluated on the next-cycle coordinates so the colour lands
  // in the same register stage as valid/x/y.
  rgb_pattern_gen u_pattern (
    .mode    (mode_n),
    .x       (x_n[7:0]),
    .y       (y_n[7:0]),
    .bar_idx (bar_idx_n),
    .solid   (solid_n),
    .rgb     (pix)
  );

  // Next-state and next-counter logic.
  always_comb begin
    state_n   = state;
    x_n       = x_coord;
    y_n       = y_coord;
    frame_n   = frame_cnt;
    blank_n   = blank_cnt;
    bar_cnt_n = bar_cnt;
    bar_idx_n = bar_idx;
    mode_n    = mode_q;
    solid_n   = solid_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = ACTIVE;
          x_n       = 16'd0;
          y_n       = 16'd0;
          frame_n   = 16'd0;
          bar_cnt_n = 16'd0;
          bar_idx_n = 3'd0;
          mode_n    = rgb_pattern_e'(mode);
          solid_n   = solid_rgb;
        end
      end
      ACTIVE: begin
        if (x_coord == LAST_X) begin
          blank_n = 16'd0;
          if (y_coord == LAST_Y) begin
            state_n = VBLANK;
            frame_n = frame_cnt + 16'd1;
          end else begin
            state_n = HBLANK;
          end
        end else begin
          x_n = x_coord + 16'd1;
          // Bar counter replaces x/(W/8).
          if (bar_cnt == LAST_BAR) begin
            bar_cnt_n = 16'd0;
            bar_idx_n = bar_idx + 3'd1;
          end else begin
            bar_cnt_n = bar_cnt + 16'd1;
          end
        end
      end
      HBLANK: begin
        if (blank_cnt == LAST_HB) begin
          state_n   = ACTIVE;
          x_n       = 16'd0;
          y_n       = y_coord + 16'd1;
          bar_cnt_n = 16'd0;
          bar_idx_n = 3'd0;
        end else begin
          blank_n = blank_cnt + 16'd1;
        end
      end
      VBLANK: begin
        if (blank_cnt == LAST_VB) begin
          if (FRAMES != 0 && frame_cnt == 16'(FRAMES)) begin
            state_n = DONE;
          end else begin
            state_n   = ACTIVE;
            x_n       = 16'd0;
            y_n       = 16'd0;
            bar_cnt_n = 16'd0;
            bar_idx_n = 3'd0;
          end
        end else begin
          blank_n = blank_cnt + 16'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, counters and all outputs registered; reset wins over start.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      state     <= IDLE;
      mode_q    <= RAMP;
      solid_q   <= 24'h000000;
      x_coord   <= 16'd0;
      y_coord   <= 16'd0;
      frame_cnt <= 16'd0;
      blank_cnt <= 16'd0;
      bar_cnt   <= 16'd0;
      bar_idx   <= 3'd0;
      valid     <= 1'b0;
      oRed      <= 8'd0;
      oGreen    <= 8'd0;
      oBlue     <= 8'd0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      mode_q    <= mode_n;
      solid_q   <= solid_n;
      x_coord   <= x_n;
      y_coord   <= y_n;
      frame_cnt <= frame_n;
      blank_cnt <= blank_n;
      bar_cnt   <= bar_cnt_n;
      bar_idx   <= bar_idx_n;
      valid     <= act_n;
      {oRed, oGreen, oBlue} <= act_n ? pix : 24'h000000;
      sof       <= act_n && (x_n == 16'd0) && (y_n == 16'd0);
      eol       <= act_n && (x_n == LAST_X);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_rgb_frame_source.sv
// Directed bench for rgb_frame_source: four instances with different geometry.
module tb_rgb_frame_source;
  import generic_pack::*;

  localparam int NI = 4;
  localparam int PW [NI]  = '{8, 16, 8, 400};
  localparam int PH [NI]  = '{2, 16, 2, 60};
  localparam int PHB [NI] = '{2, 1, 2, 1};
  localparam int PVB [NI] = '{3, 1, 3, 1};
  localparam int PF [NI]  = '{1, 1, 0, 1};
  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // ---------------- clock / reset ----------------
  logic pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  logic        rst [NI];
  logic        start [NI];
  logic [1:0]  mode_in [NI];
  logic [23:0] solid [NI];
  logic        valid [NI];
  logic [7:0]  red [NI];
  logic [7:0]  green [NI];
  logic [7:0]  blue [NI];
  logic        sof [NI];
  logic        eol [NI];
  logic [15:0] x_coord [NI];
  logic [15:0] y_coord [NI];
  logic        busy [NI];
  logic        done [NI];
  logic [15:0] frame_cnt [NI];
  src_state_e  st [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    rgb_frame_source #(
      .IMG_WIDTH(PW[g]), .IMG_HEIGHT(PH[g]), .H_BLANK(PHB[g]),
      .V_BLANK(PVB[g]), .FRAMES(PF[g])
    ) u_dut (
      .pixclk(pixclk), .reset(rst[g]), .start(start[g]), .mode(mode_in[g]),
      .solid_rgb(solid[g]), .valid(valid[g]), .oRed(red[g]), .oGreen(green[g]),
      .oBlue(blue[g]), .sof(sof[g]), .eol(eol[g]), .x_coord(x_coord[g]),
      .y_coord(y_coord[g]), .busy(busy[g]), .done(done[g]),
      .frame_cnt(frame_cnt[g]), .dbg_state(st[g])
    );
  end

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge pixclk);
    #1;
  endtask

  // After return, outputs of the cycle following the start sample are visible.
  task automatic pulse_start(input int d, input int md, input logic [23:0] s);
    mode_in[d] = 2'(md);
    solid[d]   = s;
    start[d]   = 1'b1;
    tick(1);
    start[d]   = 1'b0;
  endtask

  function automatic logic [23:0] exp_pix(input int md, input int x, input int y,
                                          input int w, input logic [23:0] s);
    logic [7:0] a, b, c;
    a = x[7:0];
    b = y[7:0];
    c = a + b;
    case (md)
      0:       return {a, b, c};
      1:       return BARS[x / (w / 8)];
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
      default: return s;
    endcase
  endfunction

  // Runs one FRAMES=1 job on instance d and acts as the downstream pixel checker.
  task automatic stream_frame(input int d, input int md, input logic [23:0] s, input int budget);
    int bx, by, beats, lx, ly;
    bit seen;
    bx = 0; by = 0; beats = 0; lx = -1; ly = -1; seen = 0;
    pulse_start(d, md, s);
    for (int c = 0; c < budget && !seen; c++) begin
      if (valid[d]) begin
        check($sformatf("d%0d_m%0d_pix_%0d_%0d", d, md, bx, by),
              {red[d], green[d], blue[d]}, exp_pix(md, bx, by, PW[d], s));
        check($sformatf("d%0d_x", d), x_coord[d], bx);
        check($sformatf("d%0d_y", d), y_coord[d], by);
        check($sformatf("d%0d_sof", d), sof[d], (bx == 0 && by == 0));
        check($sformatf("d%0d_eol", d), eol[d], (bx == PW[d] - 1));
        lx = bx; ly = by; beats++;
        bx++;
        if (bx == PW[d]) begin bx = 0; by++; end
      end
      if (done[d]) seen = 1'b1;
      else tick(1);
    end
    check($sformatf("d%0d_m%0d_done_seen", d, md), seen, 1);
    check($sformatf("d%0d_m%0d_beats", d, md), beats, PW[d] * PH[d]);
    check($sformatf("d%0d_m%0d_last_x", d, md), lx, PW[d] - 1);
    check($sformatf("d%0d_m%0d_last_y", d, md), ly, PH[d] - 1);
    tick(2);
    check($sformatf("d%0d_m%0d_idle_busy", d, md), busy[d], 0);
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, "_valid"}, valid[d], 0);
    check({tag, "_rgb"}, {red[d], green[d], blue[d]}, 0);
    check({tag, "_sof_eol"}, {sof[d], eol[d]}, 0);
    check({tag, "_xy"}, {x_coord[d], y_coord[d]}, 0);
    check({tag, "_busy_done"}, {busy[d], done[d]}, 0);
    check({tag, "_frame_cnt"}, frame_cnt[d], 0);
    check({tag, "_state"}, 32'(st[d]), 32'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int beats, sofs;
    bit ev;
    int ph;
    bit seen;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b0; start[i] = 1'b0; mode_in[i] = 2'd0; solid[i] = 24'h0;
    end
    tick(3);
    for (int i = 0; i < NI; i++) check_zero(i, $sformatf("rst%0d", i));
    for (int i = 0; i < NI; i++) rst[i] = 1'b1;
    tick(2);

    // 8x2, HB=2, VB=3, one frame of ramp: cycle-accurate timeline.
    pulse_start(0, 0, 24'h0);
    beats = 0;
    for (int k = 1; k <= 23; k++) begin
      ev = (k >= 1 && k <= 8) || (k >= 11 && k <= 18);
      check($sformatf("t1_valid_k%0d", k), valid[0], ev);
      check($sformatf("t1_done_k%0d", k), done[0], (k == 22));
      if (valid[0]) beats++;
      if (k == 1)  check("t1_sof_k1", {sof[0], red[0], green[0], blue[0]}, 32'h1000000);
      if (k == 8)  check("t1_eol_k8", {eol[0], red[0], green[0], blue[0]}, 32'h1070007);
      if (k == 12) check("t1_pix_x1y1", {red[0], green[0], blue[0]}, 24'h010102);
      if (k == 22) check("t1_busy_k22", busy[0], 1);
      if (k == 23) check("t1_busy_k23", busy[0], 0);
      tick(1);
    end
    check("t1_beats", beats, 16);
    check("t1_frame_cnt", frame_cnt[0], 1);

    // Reset in the middle of line 1 at x=3, then restart from (0,0).
    pulse_start(0, 0, 24'h0);
    tick(13);
    check("t5_pre_xy", {x_coord[0], y_coord[0]}, {16'd3, 16'd1});
    rst[0] = 1'b0;
    tick(1);
    check_zero(0, "t5_rst");
    rst[0] = 1'b1;
    pulse_start(0, 0, 24'h0);
    check("t5_restart_sof", {valid[0], sof[0]}, 2'b11);
    check("t5_restart_xy", {x_coord[0], y_coord[0]}, 0);
    check("t5_restart_pix", {red[0], green[0], blue[0]}, 24'h000000);
    tick(1);
    check("t5_restart_pix_x1", {red[0], green[0], blue[0]}, 24'h010001);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done[0]) seen = 1'b1;
      else tick(1);
    end
    check("t5_done_seen", seen, 1);
    tick(2);

    // 16x16 colour bars and checkerboard, every pixel against the model.
    stream_frame(1, 1, 24'h0, 1000);
    stream_frame(1, 2, 24'h0, 1000);

    // Free-running 8x2: 21-cycle frames, extra start pulses must be ignored.
    pulse_start(2, 0, 24'h0);
    beats = 0; sofs = 0;
    for (int k = 1; k <= 63; k++) begin
      ph = (k - 1) % 21;
      ev = (ph < 8) || (ph >= 10 && ph < 18);
      check($sformatf("t4_valid_k%0d", k), valid[2], ev);
      if (valid[2]) beats++;
      if (sof[2]) sofs++;
      if (ph == 17) check($sformatf("t4_fc_pre_k%0d", k), frame_cnt[2], (k - 1) / 21);
      if (ph == 18) check($sformatf("t4_fc_k%0d", k), frame_cnt[2], (k - 1) / 21 + 1);
      if (k == 23) check("t4_pix_f2_x1", {red[2], green[2], blue[2]}, 24'h010001);
      check($sformatf("t4_done_k%0d", k), done[2], 0);
      if (k % 7 == 3) begin
        mode_in[2] = 2'd2;
        start[2] = 1'b1;
      end else begin
        start[2] = 1'b0;
      end
      tick(1);
    end
    start[2] = 1'b0;
    check("t4_beats", beats, 48);
    check("t4_sofs", sofs, 3);
    rst[2] = 1'b0;
    tick(1);
    check_zero(2, "t4_rst");
    rst[2] = 1'b1;

    // 400-wide solid-colour frame through the pixel checker.
    stream_frame(3, 3, 24'h123456, 30000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
